// File: rtl/regfile_pc_core_pkg.sv
// Shared definitions for the register file / program counter front end:
// PC operation codes and the default datapath geometry.
package regfile_pc_core_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_NREG = 4;

  localparam logic [2:0] PCM_HOLD = 3'b000;
  localparam logic [2:0] PCM_LOAD = 3'b001;
  localparam logic [2:0] PCM_AUTO = 3'b010;
  localparam logic [2:0] PCM_STEP = 3'b011;
  localparam logic [2:0] PCM_REL  = 3'b100;

endpackage

// File: rtl/regfile_pc_core_pulse_sync.sv
// Two-flop synchroniser for an asynchronous push-button level, followed by a
// rising-edge detector that emits one clk-wide pulse per press.
module pulse_sync
  import regfile_pc_core_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/regfile_pc_core.sv
// NREG x DW dual-write register file with registered, write-first X/Y read
// ports, plus a program counter with hold/load/auto/manual-step/relative modes.
module regfile_pc_core
  import regfile_pc_core_pkg::*;
#(
  parameter int              DW     = DEF_DW,
  parameter int              NREG   = DEF_NREG,
  parameter int              AW     = $clog2(NREG),
  parameter logic [DW-1:0]   PC_RST = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DW-1:0]        data_in,
  input  logic                 wr,
  input  logic [AW-1:0]        wa,
  input  logic                 alu_we,
  input  logic [DW-1:0]        alu_res,
  input  logic [AW-1:0]        alu_dest,
  input  logic                 rd,
  input  logic [AW-1:0]        ra_x,
  input  logic [AW-1:0]        ra_y,
  input  logic [2:0]           pc_mode,
  input  logic                 manual_plus,
  output logic [DW-1:0]        X,
  output logic [DW-1:0]        Y,
  output logic [DW-1:0]        PC,
  output logic [NREG*DW-1:0]   regs_flat
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [DW-1:0] pc_q, pc_d;
  logic          step_pulse;

  pulse_sync u_step_sync (
    .clk     (clk),
    .clr     (clr),
    .async_i (manual_plus),
    .pulse_o (step_pulse)
  );

  // Port B is applied after port A so the ALU write-back wins on a shared address.
  always_comb begin
    regs_d = regs_q;
    if (wr)     regs_d[wa]       = data_in;
    if (alu_we) regs_d[alu_dest] = alu_res;
  end

  // Reading from regs_d gives the write-first bypass with the same port priority.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (rd) begin
      x_d = regs_d[ra_x];
      y_d = regs_d[ra_y];
    end
  end

  // At equal width, adding data_in modulo 2^DW is the signed relative branch.
  always_comb begin
    pc_d = pc_q;
    case (pc_mode)
      PCM_LOAD: pc_d = data_in;
      PCM_AUTO: pc_d = pc_q + 1'b1;
      PCM_STEP: if (step_pulse) pc_d = pc_q + 1'b1;
      PCM_REL:  pc_d = pc_q + data_in;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      x_q  <= '0;
      y_q  <= '0;
      pc_q <= PC_RST;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      x_q  <= x_d;
      y_q  <= y_d;
      pc_q <= pc_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = regs_q[g];
  end

  assign X  = x_q;
  assign Y  = y_q;
  assign PC = pc_q;

endmodule

// File: tb/tb_regfile_pc_core.sv
// Bench for regfile_pc_core: directed vector table, reset/manual-step
// sequences, then randomized traffic against a behavioural model.
module tb_regfile_pc_core;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic [DW-1:0]      data_in;
  logic               wr;
  logic [AW-1:0]      wa;
  logic               alu_we;
  logic [DW-1:0]      alu_res;
  logic [AW-1:0]      alu_dest;
  logic               rd;
  logic [AW-1:0]      ra_x;
  logic [AW-1:0]      ra_y;
  logic [2:0]         pc_mode;
  logic               manual_plus;
  logic [DW-1:0]      X;
  logic [DW-1:0]      Y;
  logic [DW-1:0]      PC;
  logic [NREG*DW-1:0] regs_flat;

  regfile_pc_core dut (
    .clk         (clk),
    .clr         (clr),
    .data_in     (data_in),
    .wr          (wr),
    .wa          (wa),
    .alu_we      (alu_we),
    .alu_res     (alu_res),
    .alu_dest    (alu_dest),
    .rd          (rd),
    .ra_x        (ra_x),
    .ra_y        (ra_y),
    .pc_mode     (pc_mode),
    .manual_plus (manual_plus),
    .X           (X),
    .Y           (Y),
    .PC          (PC),
    .regs_flat   (regs_flat)
  );

  int checks   = 0;
  int failures = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    data_in = '0; wr = 1'b0; wa = '0; alu_we = 1'b0; alu_res = '0; alu_dest = '0;
    rd = 1'b0; ra_x = '0; ra_y = '0; pc_mode = 3'b000; manual_plus = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic [1:0]    wa;
    logic [7:0]    din;
    logic          alu_we;
    logic [7:0]    res;
    logic [1:0]    dest;
    logic          rd;
    logic [1:0]    rx;
    logic [1:0]    ry;
    logic [2:0]    mode;
    logic [7:0]    ex;
    logic [7:0]    ey;
    logic [7:0]    epc;
    logic [31:0]   eregs;
  } vec_t;

  vec_t vecs [15];

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [4];
  logic [7:0] m_x, m_y, m_pc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_x = 8'h00; m_y = 8'h00; m_pc = 8'h00;
  endtask

  task automatic model_step();
    int sum;
    if (wr)     m_regs[wa]       = data_in;
    if (alu_we) m_regs[alu_dest] = alu_res;
    if (rd) begin
      m_x = m_regs[ra_x];
      m_y = m_regs[ra_y];
    end
    case (pc_mode)
      3'd1: m_pc = data_in;
      3'd2: m_pc = 8'((int'(m_pc) + 1) % 256);
      3'd4: begin
        sum  = int'(m_pc) + int'($signed(data_in));
        m_pc = 8'((sum + 256) % 256);
      end
      default: ;
    endcase
  endtask

  logic [7:0] base_pc;
  logic [7:0] prev_pc;
  int         n_inc;
  int         inc_cycle;

  initial begin
    vecs[0]  = '{1'b1, 2'd1, 8'hA5, 1'b0, 8'h00, 2'd0, 1'b1, 2'd1, 2'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 32'h0000_A500};
    vecs[1]  = '{1'b1, 2'd1, 8'h11, 1'b0, 8'h00, 2'd0, 1'b0, 2'd1, 2'd0, 3'd0, 8'hA5, 8'h00, 8'h00, 32'h0000_1100};
    vecs[2]  = '{1'b1, 2'd3, 8'h10, 1'b1, 8'h20, 2'd3, 1'b1, 2'd3, 2'd1, 3'd0, 8'h20, 8'h11, 8'h00, 32'h2000_1100};
    vecs[3]  = '{1'b1, 2'd3, 8'h77, 1'b0, 8'h00, 2'd0, 1'b1, 2'd3, 2'd3, 3'd0, 8'h77, 8'h77, 8'h00, 32'h7700_1100};
    vecs[4]  = '{1'b1, 2'd0, 8'h10, 1'b1, 8'h20, 2'd3, 1'b1, 2'd0, 2'd3, 3'd0, 8'h10, 8'h20, 8'h00, 32'h2000_1110};
    vecs[5]  = '{1'b0, 2'd0, 8'hFE, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd1, 8'h10, 8'h20, 8'hFE, 32'h2000_1110};
    vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd2, 8'h10, 8'h20, 8'hFF, 32'h2000_1110};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd2, 8'h10, 8'h20, 8'h00, 32'h2000_1110};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd2, 8'h10, 8'h20, 8'h01, 32'h2000_1110};
    vecs[9]  = '{1'b0, 2'd0, 8'hFC, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd4, 8'h10, 8'h20, 8'hFD, 32'h2000_1110};
    vecs[10] = '{1'b0, 2'd0, 8'h42, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd5, 8'h10, 8'h20, 8'hFD, 32'h2000_1110};
    vecs[11] = '{1'b0, 2'd0, 8'h05, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd4, 8'h10, 8'h20, 8'h02, 32'h2000_1110};
    vecs[12] = '{1'b0, 2'd0, 8'hFC, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd4, 8'h10, 8'h20, 8'hFE, 32'h2000_1110};
    vecs[13] = '{1'b0, 2'd0, 8'h33, 1'b0, 8'h00, 2'd0, 1'b0, 2'd0, 2'd0, 3'd7, 8'h10, 8'h20, 8'hFE, 32'h2000_1110};
    vecs[14] = '{1'b1, 2'd2, 8'h99, 1'b1, 8'h5A, 2'd2, 1'b1, 2'd2, 2'd1, 3'd0, 8'h5A, 8'h11, 8'hFE, 32'h205A_1110};

    // Power-on reset
    idle_inputs();
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x", 32'(X), 32'h0);
    check("rst_y", 32'(Y), 32'h0);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_regs", regs_flat, 32'h0);
    clr = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      wr = vecs[i].wr; wa = vecs[i].wa; data_in = vecs[i].din;
      alu_we = vecs[i].alu_we; alu_res = vecs[i].res; alu_dest = vecs[i].dest;
      rd = vecs[i].rd; ra_x = vecs[i].rx; ra_y = vecs[i].ry; pc_mode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d_x", i), 32'(X), 32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), 32'(Y), 32'(vecs[i].ey));
      check($sformatf("vec%0d_pc", i), 32'(PC), 32'(vecs[i].epc));
      check($sformatf("vec%0d_regs", i), regs_flat, vecs[i].eregs);
    end

    // Asynchronous reset in the middle of operation
    idle_inputs();
    wr = 1'b1; wa = 2'd2; data_in = 8'h5A; rd = 1'b1; ra_x = 2'd2; ra_y = 2'd1;
    tick();
    idle_inputs();
    pc_mode = 3'd1; data_in = 8'h37;
    tick();
    check("mid_pc_loaded", 32'(PC), 32'h37);
    check("mid_reg2", 32'(regs_flat[23:16]), 32'h5A);
    idle_inputs();
    wr = 1'b1; wa = 2'd0; data_in = 8'hEE; pc_mode = 3'd2;
    #2 clr = 1'b0;
    #1;
    check("async_rst_pc", 32'(PC), 32'h0);
    check("async_rst_x", 32'(X), 32'h0);
    check("async_rst_y", 32'(Y), 32'h0);
    check("async_rst_regs", regs_flat, 32'h0);
    @(negedge clk);
    idle_inputs();
    clr = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_pc_hold", 32'(PC), 32'h0);
    end

    // Manual step: one long press in mode 011 -> exactly one increment
    pc_mode = 3'd3;
    manual_plus = 1'b1;
    base_pc = PC;
    prev_pc = PC;
    n_inc = 0;
    inc_cycle = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (PC !== prev_pc) begin
        n_inc++;
        if (inc_cycle == 0) inc_cycle = c;
      end
      prev_pc = PC;
    end
    manual_plus = 1'b0;
    repeat (4) tick();
    check("step_count", 32'(n_inc), 32'd1);
    check("step_latency_le3", 32'(inc_cycle >= 1 && inc_cycle <= 3), 32'd1);
    check("step_pc", 32'(PC), 32'(8'(base_pc + 8'd1)));

    // Press in mode 000, then switch to 011: the pulse is discarded
    pc_mode = 3'd0;
    manual_plus = 1'b1;
    base_pc = PC;
    repeat (4) tick();
    pc_mode = 3'd3;
    repeat (6) tick();
    manual_plus = 1'b0;
    repeat (3) tick();
    check("step_discarded_pc", 32'(PC), 32'(base_pc));

    // Randomized traffic against the model
    idle_inputs();
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1)); wa = 2'($urandom_range(0, 3));
      data_in = 8'($urandom_range(0, 255));
      alu_we = 1'($urandom_range(0, 1)); alu_dest = 2'($urandom_range(0, 3));
      alu_res = 8'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      ra_x = 2'($urandom_range(0, 3)); ra_y = 2'($urandom_range(0, 3));
      pc_mode = 3'($urandom_range(0, 7));
      model_step();
      tick();
      check($sformatf("rnd%0d_x", n), 32'(X), 32'(m_x));
      check($sformatf("rnd%0d_y", n), 32'(Y), 32'(m_y));
      check($sformatf("rnd%0d_pc", n), 32'(PC), 32'(m_pc));
      check($sformatf("rnd%0d_regs", n), regs_flat, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_pc_core.md
Name: regfile_pc_core

Overview:
- Parametrised successor to the 8-bit, 4-register datapath front end: an NREG x DW register file plus a program counter with extended modes.
- The register file has two write ports: keypad/data, and ALU write-back.
- It has two registered read ports (X, Y) with write-first bypass.
- The PC supports hold, absolute load, free-run increment, debounced manual step and signed relative branch.
- Sits between the keypad/data source and the ALU. X/Y feed the ALU operands; the ALU result and destination return to write port B.

Parameters:
- DW, 8, data/register/PC width in bits.
- NREG, 4, number of general registers (power of two, >=2).
- AW, $clog2(NREG), register address width (derived, not overridden).
- PC_RST, 0, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- data_in  in  DW  keypad/external data (write port A, PC load/offset source).
- wr  in  1  write enable, port A.
- wa  in  AW  write address, port A.
- alu_we  in  1  write enable, port B (ALU write-back).
- alu_res  in  DW  ALU result.
- alu_dest  in  AW  write address, port B.
- rd  in  1  read enable; X/Y update only when 1.
- ra_x  in  AW  read address X.
- ra_y  in  AW  read address Y.
- pc_mode  in  3  PC operation select.
- manual_plus  in  1  asynchronous push-button step request.
- X  out  DW  registered read data X.
- Y  out  DW  registered read data Y.
- PC  out  DW  program counter.
- regs_flat  out  NREG*DW  all registers; reg i at bits [i*DW +: DW], for display.

Behaviour:
Reset:
- clr=0 asynchronously forces all registers, X and Y to 0 and PC to PC_RST.
- The manual_plus synchroniser and edge flop clear to 0.
- Release is seen on the first rising clk with clr=1.

Register writes (1-cycle latency):
- Port A: wr=1 writes data_in to reg[wa].
- Port B: alu_we=1 writes alu_res to reg[alu_dest].
- Both ports enabled with different addresses: both writes happen.
- Both ports enabled with the same address: port B (ALU) wins.

Reads:
- rd=1: X <= value of reg[ra_x] as it will be after this edge's writes (write-first bypass, same port priority). Y is the same for ra_y.
- rd=0: X/Y hold.
- Same address on X and Y is legal.

manual_plus handling:
- Two-flop synchroniser, then a rising-edge detector producing step_pulse (one clk wide per button press).
- Latency from a stable manual_plus edge to step_pulse is 2-3 clk.

PC modes (pc_mode):
- 000 hold.
- 001 load: PC <= data_in.
- 010 auto: PC <= PC+1 every clk.
- 011 manual: PC <= PC+1 only on clocks where step_pulse=1.
- 100 relative: PC <= PC + sign-extended data_in (two's complement, DW bits).
- 101-111 hold (reserved).

Arithmetic and boundaries:
- All PC arithmetic is modulo 2^DW. 0xFF+1 = 0x00; 0x02 + 0xFC = 0xFE.
- A step_pulse arriving while not in mode 011 is discarded, not queued.
- Changing pc_mode takes effect on the next edge; there is no pipeline.
- Reset asserted mid-operation aborts any pending step and any write.
- regs_flat is driven combinationally from the register array; no extra latency.

Decomposition:
- Shared package: PC mode localparams (PCM_HOLD=3'b000, PCM_LOAD=3'b001, PCM_AUTO=3'b010, PCM_STEP=3'b011, PCM_REL=3'b100) and the DW=8 / NREG=4 defaults.
- One sub-module, pulse_sync (2-flop synchroniser plus rising-edge detector, reset clr), instanced for manual_plus.
- Register file and PC logic live in regfile_pc_core itself.

Test Plan:
- Reset: hold clr=0 mid-run with PC=0x37 and reg2=0x5A -> PC, X, Y and all regs read 0 immediately, without waiting for a clk edge. After release, PC stays 0 with pc_mode=000.
- Write/read with bypass: wr=1, wa=1, data_in=0xA5, rd=1, ra_x=1 in the same cycle -> X=0xA5 after that edge. rd=0 next cycle with a new write of 0x11 -> X holds 0xA5.
- Port conflict: wr=1, wa=3, data_in=0x10 and alu_we=1, alu_dest=3, alu_res=0x20 -> reg3=0x20. Different addresses (wa=0, alu_dest=3) -> reg0=0x10 and reg3=0x20.
- PC modes: load 0xFE (001), then auto (010) for 3 clk -> 0xFF, 0x00, 0x01. Relative (100) with data_in=0xFC from 0x01 -> 0xFD.
- Manual step: pc_mode=011, one manual_plus press held 10 clk -> PC increments exactly once, within 3 clk of the press. A press made in mode 000 followed by a switch to 011 -> no increment.
